// File: rtl/imem_loader_if.sv
// Byte-stream load request and memory write port of imem_loader.
// slave: loader side. master: host/bench side.
interface imem_loader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;
    logic [ADDR_W:0]   words_written;

    modport master (
        output start, base_addr, word_count, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata,
        input  busy, done, checksum, words_written
    );

    modport slave (
        input  start, base_addr, word_count, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata,
        output busy, done, checksum, words_written
    );
endinterface

// File: rtl/imem_loader.sv
// Packs a big-endian byte stream into words and writes them to imem.
// Ports: clk, rst_n (async low), bus (imem_loader_if.slave).
module imem_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_loader_if.slave bus
);
    localparam int BPW    = DATA_W / 8;
    localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BPW - 1);
    localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [DATA_W+7:0] shifted;

    // Oldest byte ends up in the top byte lane.
    assign shifted = {word_q, bus.byte_in};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        word_d   = word_q;
        bcnt_d   = bcnt_q;
        csum_d   = csum_q;
        wcnt_d   = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.base_addr;
                    remain_d = bus.word_count;
                    word_d   = '0;
                    bcnt_d   = '0;
                    csum_d   = '0;
                    wcnt_d   = '0;
                    state_d  = (bus.word_count == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (bus.byte_valid) begin
                    word_d = shifted[DATA_W-1:0];
                    if (bcnt_q == BCNT_LAST) begin
                        bcnt_d  = '0;
                        state_d = WRITE;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
            end
            WRITE: begin
                csum_d   = csum_q ^ word_q;
                wcnt_d   = wcnt_q + (ADDR_W+1)'(1);
                remain_d = remain_q - (ADDR_W+1)'(1);
                addr_d   = addr_q + ADDR_W'(1);
                state_d  = (remain_q == REM_ONE) ? DONE : FILL;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            word_q   <= '0;
            bcnt_q   <= '0;
            csum_q   <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            word_q   <= word_d;
            bcnt_q   <= bcnt_d;
            csum_q   <= csum_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Write port is forced to zero outside the single WRITE cycle.
    assign bus.byte_ready    = (state_q == FILL);
    assign bus.mem_we        = (state_q == WRITE);
    assign bus.mem_addr      = (state_q == WRITE) ? addr_q : '0;
    assign bus.mem_wdata     = (state_q == WRITE) ? word_q : '0;
    assign bus.busy          = (state_q == FILL) || (state_q == WRITE);
    assign bus.done          = (state_q == DONE);
    assign bus.checksum      = csum_q;
    assign bus.words_written = wcnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Drives and samples on the falling clock edge.
module tb_imem_loader;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   done_cnt;
    int   wr_rdy_bad;
    int   n;
    int   wq_sz;
    int   dc0;
    logic [43:0] wq[$];

    imem_loader_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    imem_loader #(.ADDR_W(12), .DATA_W(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write and done pulse seen mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_we) wq.push_back({bus.mem_addr, bus.mem_wdata});
        if (bus.done) done_cnt++;
        if (bus.mem_we && bus.byte_ready) wr_rdy_bad++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        k = 0;
        while (!bus.byte_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("byte_accept_timeout", 0, 1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic do_start(input logic [11:0] b, input logic [12:0] c);
        bus.start      = 1'b1;
        bus.base_addr  = b;
        bus.word_count = c;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!bus.done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(tag, bus.done, 1);
        @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input int idx,
                          input logic [11:0] a, input logic [31:0] d);
        logic [43:0] e;
        e = (idx < wq.size()) ? wq[idx] : 44'hx;
        chk({tag, "_addr"}, e[43:32], a);
        chk({tag, "_data"}, e[31:0], d);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        done_cnt   = 0;
        wr_rdy_bad = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        #12;
        chk("rst_ready", bus.byte_ready, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_csum", bus.checksum, 0);
        chk("rst_ww", bus.words_written, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single word, back-to-back bytes
        do_start(12'h000, 13'd1);
        chk("t1_busy", bus.busy, 1);
        chk("t1_ready", bus.byte_ready, 1);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        chk("t1_we", bus.mem_we, 1);
        chk("t1_addr", bus.mem_addr, 12'h000);
        chk("t1_data", bus.mem_wdata, 32'h12345678);
        chk("t1_ready_wr", bus.byte_ready, 0);
        @(negedge clk);
        chk("t1_done", bus.done, 1);
        chk("t1_we_off", bus.mem_we, 0);
        chk("t1_busy_off", bus.busy, 0);
        chk("t1_csum", bus.checksum, 32'h12345678);
        chk("t1_ww", bus.words_written, 1);
        @(negedge clk);
        chk("t1_done_1cyc", bus.done, 0);

        // 2: address wrap 0xFFE..0x000
        wq.delete();
        do_start(12'hFFE, 13'd3);
        for (int i = 1; i <= 12; i++) send_byte(8'(i), 0);
        wait_done("t2_done");
        chk("t2_nwr", wq.size(), 3);
        chk_wr("t2_w0", 0, 12'hFFE, 32'h01020304);
        chk_wr("t2_w1", 1, 12'hFFF, 32'h05060708);
        chk_wr("t2_w2", 2, 12'h000, 32'h090A0B0C);
        chk("t2_ww", bus.words_written, 3);
        chk("t2_csum", bus.checksum, 32'h0D0E0F00);
        chk("t2_ready_in_wr", wr_rdy_bad, 0);

        // 3: zero-length load
        wq_sz = wq.size();
        dc0   = done_cnt;
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h55;
        do_start(12'h123, 13'd0);
        chk("t3_done", bus.done, 1);
        chk("t3_ready", bus.byte_ready, 0);
        chk("t3_busy", bus.busy, 0);
        chk("t3_ww", bus.words_written, 0);
        chk("t3_csum", bus.checksum, 0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        chk("t3_done_off", bus.done, 0);
        chk("t3_nowr", wq.size(), wq_sz);
        chk("t3_done_cnt", done_cnt - dc0, 1);

        // 4: random valid gaps
        wq.delete();
        do_start(12'h100, 13'd2);
        send_byte(8'hFF, $urandom_range(0, 3));
        send_byte(8'hFF, $urandom_range(0, 3));
        send_byte(8'h00, $urandom_range(0, 3));
        send_byte(8'h00, $urandom_range(0, 3));
        send_byte(8'h0F, $urandom_range(0, 3));
        send_byte(8'h0F, $urandom_range(0, 3));
        send_byte(8'h0F, $urandom_range(0, 3));
        send_byte(8'h0F, $urandom_range(0, 3));
        wait_done("t4_done");
        chk("t4_nwr", wq.size(), 2);
        chk_wr("t4_w0", 0, 12'h100, 32'hFFFF0000);
        chk_wr("t4_w1", 1, 12'h101, 32'h0F0F0F0F);
        chk("t4_csum", bus.checksum, 32'hF0F00F0F);
        chk("t4_ww", bus.words_written, 2);

        // 5: reset in the middle of word 2
        wq.delete();
        do_start(12'h200, 13'd2);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        wq_sz = wq.size();
        dc0   = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_ready", bus.byte_ready, 0);
        chk("t5_rst_we", bus.mem_we, 0);
        chk("t5_rst_addr", bus.mem_addr, 0);
        chk("t5_rst_csum", bus.checksum, 0);
        chk("t5_rst_ww", bus.words_written, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_no_wr", wq.size(), wq_sz);
        chk("t5_no_done", done_cnt - dc0, 0);
        wq.delete();
        do_start(12'h300, 13'd1);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        wait_done("t5_done");
        chk("t5_nwr", wq.size(), 1);
        chk_wr("t5_w0", 0, 12'h300, 32'hDEADBEEF);
        chk("t5_csum", bus.checksum, 32'hDEADBEEF);

        // 6: start ignored in FILL, WRITE and DONE
        wq.delete();
        dc0 = done_cnt;
        do_start(12'h010, 13'd2);
        do_start(12'h050, 13'd7);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        chk("t6_in_write", bus.mem_we, 1);
        do_start(12'h070, 13'd5);
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        send_byte(8'h07, 0);
        send_byte(8'h08, 0);
        @(negedge clk);
        chk("t6_in_done", bus.done, 1);
        do_start(12'h090, 13'd4);
        repeat (4) @(negedge clk);
        chk("t6_idle", bus.busy, 0);
        chk("t6_nwr", wq.size(), 2);
        chk_wr("t6_w0", 0, 12'h010, 32'h01020304);
        chk_wr("t6_w1", 1, 12'h011, 32'h05060708);
        chk("t6_ww", bus.words_written, 2);
        chk("t6_done_cnt", done_cnt - dc0, 1);
        chk("ready_in_wr_all", wr_rdy_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
